// File: rtl/sipo_deserializer.sv
// Serial-to-parallel word assembler fed by the 4-bit PISO, with a valid/ready output and sticky overrun.
// Define SIPO_MSB_FIRST_EN to make the first received bit land in parallel_o[W-1].
module sipo_deserializer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_i,
  input  logic         valid_i,
  input  logic         flush_i,
  input  logic         ready_i,
  output logic [W-1:0] parallel_o,
  output logic         valid_o,
  output logic         busy_o,
  output logic         overrun_o
);
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  sr;
  logic [W-1:0]  sr_next;
  logic [CW-1:0] cnt;
  logic          capture;
  logic          complete;

`ifdef SIPO_MSB_FIRST_EN
  assign sr_next = {sr[W-2:0], serial_i};
`else
  assign sr_next = {serial_i, sr[W-1:1]};
`endif

  // flush beats a valid bit arriving in the same cycle
  assign capture  = valid_i && !flush_i;
  assign complete = capture && (cnt == LAST);
  assign busy_o   = (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sr         <= '0;
      cnt        <= '0;
      parallel_o <= '0;
      valid_o    <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      if (flush_i) begin
        cnt <= '0;
      end else if (valid_i) begin
        sr  <= sr_next;
        cnt <= complete ? '0 : cnt + CW'(1);
      end

      if (complete) begin
        parallel_o <= sr_next;
        valid_o    <= 1'b1;
        if (valid_o && !ready_i)
          overrun_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed plus random stimulus for sipo_deserializer, checked against a queue-based word model.
module tb_sipo_deserializer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, serial_i, valid_i, flush_i, ready_i;
  logic [W-1:0] parallel_o;
  logic         valid_o, busy_o, overrun_o;

  int vectors = 0;
  int miscompares = 0;

  // reference model: bits received so far in the current word, plus output state
  bit           bits_q[$];
  logic [W-1:0] m_par;
  bit           m_vld, m_ovr;

`ifdef SIPO_MSB_FIRST_EN
  localparam logic [W-1:0] EXP_D = 4'hB;
  localparam logic [W-1:0] EXP_R = 4'h4;
`else
  localparam logic [W-1:0] EXP_D = 4'hD;
  localparam logic [W-1:0] EXP_R = 4'h2;
`endif

  sipo_deserializer #(.W(W)) dut (
    .clk(clk), .reset(reset), .serial_i(serial_i), .valid_i(valid_i),
    .flush_i(flush_i), .ready_i(ready_i), .parallel_o(parallel_o),
    .valid_o(valid_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] word;
    bit done;
    done = 1'b0;
    word = '0;
    if (reset) begin
      bits_q.delete();
      m_par = '0; m_vld = 1'b0; m_ovr = 1'b0;
      return;
    end
    if (flush_i) bits_q.delete();
    else if (valid_i) begin
      bits_q.push_back(serial_i);
      if (bits_q.size() == W) begin
        for (int i = 0; i < W; i++) begin
`ifdef SIPO_MSB_FIRST_EN
          if (bits_q[i]) word = word | (W'(1) << (W - 1 - i));
`else
          if (bits_q[i]) word = word | (W'(1) << i);
`endif
        end
        bits_q.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (m_vld && !ready_i) m_ovr = 1'b1;
      m_par = word;
      m_vld = 1'b1;
    end else if (m_vld && ready_i) m_vld = 1'b0;
  endtask

  // apply inputs, clock once, update model, check all outputs
  task automatic step(input bit r, input bit v, input bit s, input bit f, input bit rd);
    reset = r; valid_i = v; serial_i = s; flush_i = f; ready_i = rd;
    @(posedge clk);
    model_edge();
    #1;
    chk("parallel", parallel_o, m_par);
    chk("valid", W'(valid_o), W'(m_vld));
    chk("busy", W'(busy_o), W'(bits_q.size() != 0));
    chk("overrun", W'(overrun_o), W'(m_ovr));
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rd);
    for (int i = 0; i < W; i++) step(0, 1, w[i], 0, rd);
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; serial_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    #1;
    step(1, 0, 0, 0, 0);
    chk("reset_par", parallel_o, '0);

    // single word, always ready: 1,0,1,1
    send_word(4'hD, 1);
    chk("word_d", parallel_o, EXP_D);
    step(0, 0, 0, 0, 1);

    // same word with a 3-cycle gap after bit 2
    step(0, 1, 1, 0, 1);
    step(0, 1, 0, 0, 1);
    repeat (3) step(0, 0, 1, 0, 1);
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 0, 1);
    chk("gap_d", parallel_o, EXP_D);

    // overrun with ready low, then drain
    send_word(4'hA, 0);
    send_word(4'h5, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // completion coincides with a transfer
    step(1, 0, 0, 0, 0);
    send_word(4'h3, 0);
    for (int i = 0; i < W - 1; i++) step(0, 1, (4'hC >> i) & 1'b1, 0, 0);
    step(0, 1, 1'b1, 0, 1);
    step(0, 0, 0, 0, 1);

    // flush a partial word, then a full word of ones
    step(0, 1, 1, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 1, 1);
    send_word(4'hF, 1);
    chk("flush_f", parallel_o, 4'hF);

    // reset mid-word with a pending output
    send_word(4'h6, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("rst_par", parallel_o, '0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    chk("rst_word", parallel_o, EXP_R);

    // random traffic
    for (int n = 0; n < 600; n++)
      step($urandom_range(99) == 0, $urandom_range(9) < 7, $urandom_range(1) == 1,
           $urandom_range(19) == 0, $urandom_range(1) == 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-to-parallel stage that sits directly downstream of the 4-bit PISO.
- Consumes the PISO's serial_o/valid_o stream, LSB first, and reassembles W-bit words.
- Presents each word on a registered parallel port with a valid/ready handshake.
- Tolerates gaps in the serial valid, supports flushing a partial word, and flags lost words.

Parameters:
- W, 4, word width in bits (>=2); default matches the PISO word.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; sampled on the clk rising edge.
- serial_i  input  1  serial data bit; connects to PISO serial_o.
- valid_i  input  1  serial_i carries a valid bit this cycle; connects to PISO valid_o.
- flush_i  input  1  discard any partial word.
- ready_i  input  1  downstream accepts parallel_o this cycle.
- parallel_o  output  W  assembled word; registered.
- valid_o  output  1  parallel_o holds an unaccepted word.
- busy_o  output  1  a partial word is in progress (bit count != 0).
- overrun_o  output  1  sticky: an unaccepted word was overwritten.

Behaviour:
- Reset: parallel_o=0, valid_o=0, busy_o=0, overrun_o=0, internal shift register=0, bit counter=0.
- Internal state: W-bit shift register sr; bit counter cnt, range 0..W-1, width $clog2(W).
- Bit capture:
  - valid_i=1 and flush_i=0: sr <= {serial_i, sr[W-1:1]}, so the first received bit ends in bit 0.
  - valid_i=0: sr and cnt hold. Gaps of any length are legal.
- Word completion: valid_i=1, flush_i=0 and cnt==W-1.
  - parallel_o <= {serial_i, sr[W-1:1]}, valid_o <= 1, cnt <= 0.
  - Otherwise a captured bit increments cnt.
- Latency: valid_o rises on the edge that samples the W-th bit. Back-to-back PISO words give one word every W valid cycles.
- Handshake:
  - Transfer occurs when valid_o=1 and ready_i=1; valid_o then clears on that edge unless a completion happens on the same edge.
  - parallel_o is stable while valid_o=1 and ready_i=0, except on overrun.
  - ready_i is ignored while valid_o=0.
- Simultaneous completion and transfer: the old word is transferred, the new word is loaded, valid_o stays 1, no overrun.
- Overrun: completion while valid_o=1 and ready_i=0.
  - New word overwrites parallel_o, valid_o stays 1, overrun_o <= 1.
  - overrun_o holds until reset.
- Flush: flush_i=1 sets cnt <= 0.
  - The bit on valid_i that cycle is dropped; flush wins.
  - sr content is don't-care after flush.
  - parallel_o, valid_o and overrun_o are unaffected.
- busy_o = (cnt != 0), combinational from the registered cnt.
- Reset mid-word or with a pending output: everything returns to reset values on that edge. Partial and pending words are lost and overrun_o is not set.

Optional Feature:
- Macro: SIPO_MSB_FIRST_EN.
- Defined: the shift direction reverses, sr <= {sr[W-2:0], serial_i], so the first received bit lands in parallel_o[W-1]. All handshake, counter, flush and overrun behaviour is unchanged.
- Undefined: LSB-first assembly as described in Behaviour, which matches the PISO.

Test Plan:
- W=4, ready_i=1. Drive valid_i=1 with serial_i=1,0,1,1 on consecutive cycles -> valid_o=1 for exactly one cycle right after the 4th edge, parallel_o=4'hD, busy_o=1 during bits 2-4, overrun_o=0.
- Same bits with valid_i=0 for 3 cycles between bit 2 and bit 3 -> parallel_o=4'hD after the 4th valid bit; busy_o held at 1 through the gap.
- ready_i=0. Send words 4'hA then 4'h5 back to back -> after the first word valid_o=1, parallel_o=4'hA. After the second, parallel_o=4'h5 and overrun_o=1. Raise ready_i -> valid_o clears next edge; overrun_o stays 1.
- ready_i pulsed on the same edge the second word completes (first word 4'h3, second 4'hC) -> 4'h3 is transferred, parallel_o=4'hC, valid_o stays 1, overrun_o=0.
- Send 2 bits, assert flush_i with valid_i=1 for one cycle, then send 1,1,1,1 -> busy_o=0 after the flush, and the next word completes after exactly 4 more bits with parallel_o=4'hF.
- Assert reset after 3 bits with a word pending -> all outputs 0 next edge. Then 0,1,0,0 -> parallel_o=4'h2, or 4'h4 with SIPO_MSB_FIRST_EN defined.
